seven_segment: RTL and testbench
================================

// Module: seven_segment
// PURPOSE
//   Registered BCD-to-seven-segment decoder for a single display digit.
//   Accepts a 4-bit BCD code and drives the seven segment lines (a..g), the
//   decimal point and an invalid-code flag.
//   Sits between numeric datapath logic (counters, BCD converters) and the
//   display pins or digit multiplexer.
// PARAMETERS
//   ACTIVE_LOW  0  1 = seg/dp outputs inverted (common-anode); 0 = lit segment is 1
// PORTS
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous, active-high reset
//   bcd      in   4  digit code to display
//   blank    in   1  1 = all segments and dp off this digit
//   dp_in    in   1  decimal point request
//   seg      out  7  segments; seg[0]=a, seg[1]=b ... seg[6]=g
//   dp       out  1  decimal point segment
//   invalid  out  1  1 = registered code was not displayable
// BEHAVIOUR
//   - One clock, one async active-high reset.
//   - All outputs are registered: inputs sampled at edge N appear after edge N.
//     Latency is exactly 1 cycle, with no handshake.
//   - Reset value (while rst=1, immediately, independent of clk):
//     seg = all off, dp = off, invalid = 0.
//     All off means 7'h00/0 when ACTIVE_LOW=0, and 7'h7F/1 when ACTIVE_LOW=1.
//   - Glyphs (active-high, {g..a}):
//     0=7'h3F  1=7'h06  2=7'h5B  3=7'h4F  4=7'h66
//     5=7'h6D  6=7'h7D  7=7'h07  8=7'h7F  9=7'h6F
//   - Codes 10..15 without HEX_DIGITS_EN: seg = dash (7'h40), invalid = 1.
//   - dp = dp_in, registered alongside seg.
//   - blank=1 overrides everything: seg and dp off, invalid = 0.
//   - Polarity: ACTIVE_LOW inverts seg and dp only. invalid is never inverted.
//   - Input change every cycle: each cycle's code is reflected independently.
//     There is no hysteresis.
//   - Reset deassertion: the first decoded value appears on the first rising
//     edge after rst falls.
// CONFIGURATION
//   HEX_DIGITS_EN defined:
//     Codes 10..15 show hex glyphs A=7'h77 b=7'h7C C=7'h39 d=7'h5E E=7'h79 F=7'h71.
//     invalid is tied to 0.
//   HEX_DIGITS_EN undefined:
//     Codes 10..15 show dash 7'h40 with invalid = 1, as described above.
// STRUCTURE
//   - Package seven_segment_pkg:
//     - glyph localparams GLYPH_0..GLYPH_9, GLYPH_A..GLYPH_F, GLYPH_DASH, GLYPH_OFF
//     - segment index constants SEG_A..SEG_G
//   - Sub-module seven_segment_rom: purely combinational code -> {glyph, invalid}
//     lookup, honouring HEX_DIGITS_EN.
//   - Top level handles blank, polarity and the output registers.
// TESTING
//   1. rst=1 with bcd=8 and dp_in=1 -> seg=7'h00, dp=0, invalid=0 during reset,
//      with no clock edge required.
//   2. Sweep bcd 0..9, one code per cycle -> one cycle later seg follows
//      3F,06,5B,4F,66,6D,7D,07,7F,6F and invalid=0.
//   3. bcd=4'hA..F without HEX_DIGITS_EN -> seg=7'h40, invalid=1.
//      With HEX_DIGITS_EN -> seg follows 77,7C,39,5E,79,71 and invalid=0.
//   4. bcd=3, dp_in=1, blank=1 -> seg=7'h00, dp=0.
//      Then blank=0 -> seg=7'h4F, dp=1 next cycle.
//   5. ACTIVE_LOW=1 with bcd=1 -> seg=7'h79, dp=1 (off); reset value seg=7'h7F.
//   6. Assert rst mid-sweep at bcd=7 -> outputs off immediately.
//      Release rst -> seg=7'h07 after the first rising edge.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - glyph and segment-index constants for the seven-segment decoder
//
// Glyphs are active-high and packed {g,f,e,d,c,b,a}, so bit 0 is segment a.
// Polarity inversion for common-anode displays is applied by the top level.

package seven_segment_pkg;

    localparam int SEG_W = 7;

    // Segment bit positions within the seg bus
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Decimal digits
    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;

    // Hex letters (A, b, C, d, E, F)
    localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

    // Dash marks a code that cannot be shown; only segment g lit
    localparam logic [SEG_W-1:0] GLYPH_DASH = 7'h40;
    localparam logic [SEG_W-1:0] GLYPH_OFF  = 7'h00;

    // Map an active-high segment pattern onto the pin polarity
    function automatic logic [SEG_W-1:0] to_pins(input logic [SEG_W-1:0] glyph,
                                                 input logic active_low);
        return active_low ? ~glyph : glyph;
    endfunction

endpackage

// File: rtl/seven_segment_rom.sv
// rtl/seven_segment_rom.sv - combinational BCD code to glyph lookup
//
// Configuration macro: HEX_DIGITS_EN
//   defined   : codes 10..15 show A b C d E F, invalid is never set
//   undefined : codes 10..15 show a dash and raise invalid
//
// Ports:
//   code     in   4  digit code
//   glyph    out  7  active-high segment pattern {g..a}
//   invalid  out  1  code has no displayable glyph

module seven_segment_rom
    import seven_segment_pkg::*;
(
    input  logic [3:0]       code,
    output logic [SEG_W-1:0] glyph,
    output logic             invalid
);

    always_comb begin
        glyph   = GLYPH_OFF;
        invalid = 1'b0;
        unique case (code)
            4'd0: glyph = GLYPH_0;
            4'd1: glyph = GLYPH_1;
            4'd2: glyph = GLYPH_2;
            4'd3: glyph = GLYPH_3;
            4'd4: glyph = GLYPH_4;
            4'd5: glyph = GLYPH_5;
            4'd6: glyph = GLYPH_6;
            4'd7: glyph = GLYPH_7;
            4'd8: glyph = GLYPH_8;
            4'd9: glyph = GLYPH_9;
`ifdef HEX_DIGITS_EN
            4'd10: glyph = GLYPH_A;
            4'd11: glyph = GLYPH_B;
            4'd12: glyph = GLYPH_C;
            4'd13: glyph = GLYPH_D;
            4'd14: glyph = GLYPH_E;
            4'd15: glyph = GLYPH_F;
`else
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: begin
                glyph   = GLYPH_DASH;
                invalid = 1'b1;
            end
`endif
            default: begin
                glyph   = GLYPH_OFF;
                invalid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seven_segment.sv
// rtl/seven_segment.sv - registered BCD to seven-segment decoder for one digit
//
// Configuration macro: HEX_DIGITS_EN (hex glyphs for codes 10..15, see seven_segment_rom)
//
// Parameters:
//   ACTIVE_LOW  1 = seg/dp driven inverted for common-anode displays
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   bcd      in   4  digit code
//   blank    in   1  force all segments and dp off
//   dp_in    in   1  decimal point request
//   seg      out  7  segment pins, seg[0]=a .. seg[6]=g
//   dp       out  1  decimal point pin
//   invalid  out  1  registered code was not displayable (never inverted)
//
// All outputs change one clock after their inputs are sampled.

module seven_segment
    import seven_segment_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       bcd,
    input  logic             blank,
    input  logic             dp_in,
    output logic [SEG_W-1:0] seg,
    output logic             dp,
    output logic             invalid
);

    // "All off" as seen on the pins for the configured polarity
    localparam logic [SEG_W-1:0] SEG_OFF_PINS = ACTIVE_LOW ? ~GLYPH_OFF : GLYPH_OFF;
    localparam logic             DP_OFF_PINS  = ACTIVE_LOW;

    logic [SEG_W-1:0] rom_glyph;
    logic             rom_invalid;

    logic [SEG_W-1:0] seg_next;
    logic             dp_next;
    logic             invalid_next;

    seven_segment_rom u_rom (
        .code    (bcd),
        .glyph   (rom_glyph),
        .invalid (rom_invalid)
    );

    // Blank wins over both the glyph and the decimal point, and also
    // suppresses invalid since nothing is being displayed.
    always_comb begin
        seg_next     = SEG_OFF_PINS;
        dp_next      = DP_OFF_PINS;
        invalid_next = 1'b0;
        if (!blank) begin
            seg_next     = to_pins(rom_glyph, ACTIVE_LOW);
            dp_next      = dp_in ^ ACTIVE_LOW;
            invalid_next = rom_invalid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg     <= SEG_OFF_PINS;
            dp      <= DP_OFF_PINS;
            invalid <= 1'b0;
        end else begin
            seg     <= seg_next;
            dp      <= dp_next;
            invalid <= invalid_next;
        end
    end

endmodule

// File: tb/tb_seven_segment.sv
// tb/tb_seven_segment.sv - self-checking bench for seven_segment (both polarities)

module tb_seven_segment;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] bcd = 4'd0;
    logic       blank = 1'b0;
    logic       dp_in = 1'b0;

    logic [6:0] seg_h, seg_l;
    logic       dp_h, dp_l;
    logic       inv_h, inv_l;

    int n_cmp = 0;
    int n_err = 0;

    seven_segment #(.ACTIVE_LOW(1'b0)) u_dut_h (
        .clk(clk), .rst(rst), .bcd(bcd), .blank(blank), .dp_in(dp_in),
        .seg(seg_h), .dp(dp_h), .invalid(inv_h)
    );

    seven_segment #(.ACTIVE_LOW(1'b1)) u_dut_l (
        .clk(clk), .rst(rst), .bcd(bcd), .blank(blank), .dp_in(dp_in),
        .seg(seg_l), .dp(dp_l), .invalid(inv_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] bcd;
        logic       blank;
        logic       dp_in;
        logic [6:0] seg;   // active-high expectation
        logic       dp;
        logic       inv;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Check both instances against one active-high expectation
    task automatic chk_all(input string tag, input logic [6:0] s, input logic d, input logic i);
        logic [6:0] s_l;
        s_l = ~s;
        chk({tag, " seg_h"}, {1'b0, seg_h}, {1'b0, s});
        chk({tag, " dp_h"},  {7'd0, dp_h},  {7'd0, d});
        chk({tag, " inv_h"}, {7'd0, inv_h}, {7'd0, i});
        chk({tag, " seg_l"}, {1'b0, seg_l}, {1'b0, s_l});
        chk({tag, " dp_l"},  {7'd0, dp_l},  {7'd0, ~d});
        chk({tag, " inv_l"}, {7'd0, inv_l}, {7'd0, i});
    endtask

    initial begin
        logic [6:0] hex_exp [6];
        logic       hex_inv;
        hex_exp = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef HEX_DIGITS_EN
        hex_inv = 1'b0;
`else
        hex_inv = 1'b1;
        hex_exp = '{default: 7'h40};
`endif

        vecs.push_back('{4'd0, 1'b0, 1'b0, 7'h3F, 1'b0, 1'b0});
        vecs.push_back('{4'd1, 1'b0, 1'b1, 7'h06, 1'b1, 1'b0});
        vecs.push_back('{4'd2, 1'b0, 1'b0, 7'h5B, 1'b0, 1'b0});
        vecs.push_back('{4'd3, 1'b0, 1'b1, 7'h4F, 1'b1, 1'b0});
        vecs.push_back('{4'd4, 1'b0, 1'b0, 7'h66, 1'b0, 1'b0});
        vecs.push_back('{4'd5, 1'b0, 1'b0, 7'h6D, 1'b0, 1'b0});
        vecs.push_back('{4'd6, 1'b0, 1'b1, 7'h7D, 1'b1, 1'b0});
        vecs.push_back('{4'd7, 1'b0, 1'b0, 7'h07, 1'b0, 1'b0});
        vecs.push_back('{4'd8, 1'b0, 1'b1, 7'h7F, 1'b1, 1'b0});
        vecs.push_back('{4'd9, 1'b0, 1'b0, 7'h6F, 1'b0, 1'b0});
        for (int k = 0; k < 6; k++)
            vecs.push_back('{4'(10 + k), 1'b0, 1'(k % 2), hex_exp[k], 1'(k % 2), hex_inv});
        // blank overrides glyph, dp and invalid; then release
        vecs.push_back('{4'd3,  1'b1, 1'b1, 7'h00, 1'b0, 1'b0});
        vecs.push_back('{4'd3,  1'b0, 1'b1, 7'h4F, 1'b1, 1'b0});
        vecs.push_back('{4'd12, 1'b1, 1'b1, 7'h00, 1'b0, 1'b0});
        vecs.push_back('{4'd8,  1'b1, 1'b0, 7'h00, 1'b0, 1'b0});
        vecs.push_back('{4'd1,  1'b0, 1'b0, 7'h06, 1'b0, 1'b0});

        // Asynchronous reset with no clock edge: inputs would light 8 with dp
        bcd = 4'd8; dp_in = 1'b1;
        #1 rst = 1'b1;
        #1 chk_all("reset_async", 7'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_all("reset_held", 7'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // Table sweep, one vector per cycle
        foreach (vecs[n]) begin
            bcd = vecs[n].bcd; blank = vecs[n].blank; dp_in = vecs[n].dp_in;
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", n), vecs[n].seg, vecs[n].dp, vecs[n].inv);
        end

        // Latency: output must not move before the edge
        bcd = 4'd2; dp_in = 1'b1; blank = 1'b0;
        #2 chk_all("latency_hold", 7'h06, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_all("latency_edge", 7'h5B, 1'b1, 1'b0);

        // Mid-sweep reset at bcd=7
        dp_in = 1'b0;
        bcd = 4'd6; @(posedge clk); #1;
        chk_all("mid_6", 7'h7D, 1'b0, 1'b0);
        bcd = 4'd7;
        #1 rst = 1'b1;
        #1 chk_all("mid_rst_now", 7'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_all("mid_rst_edge", 7'h00, 1'b0, 1'b0);
        rst = 1'b0;
        #2 chk_all("mid_rel_wait", 7'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_all("mid_rel_first", 7'h07, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
